// File: rtl/dff_skid_slice.sv
// Valid/ready register slice with a 2-entry skid buffer; in_ready and out_valid come from registered state only.
// Optional stall cycle counter enabled by defining DFF_SKID_STALL_CNT_EN.
module dff_skid_slice #(
    parameter int N     = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [N-1:0]     out_data,
    output logic             out_valid,
    input  logic             out_ready
`ifdef DFF_SKID_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt
`endif
);

    // state | meaning
    // EMPTY | no word held, out_valid=0
    // ONE   | main_q holds the word being presented
    // TWO   | main_q presented, skid_q holds the next word, in_ready=0
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic [N-1:0]   main_q, main_d;
    logic [N-1:0]   skid_q, skid_d;
    logic           in_fire;
    logic           out_fire;

    assign in_ready  = (state_q != TWO);
    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_q;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    main_d  = in_data;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    main_d = in_data;
                end else if (in_fire) begin
                    skid_d  = in_data;
                    state_d = TWO;
                end else if (out_fire) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (out_fire) begin
                    main_d  = skid_q;
                    state_d = ONE;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end

`ifdef DFF_SKID_STALL_CNT_EN
    logic [CNT_W-1:0] stall_q, stall_d;

    // Saturating: holds at all-ones rather than wrapping.
    always_comb begin
        stall_d = stall_q;
        if (out_valid && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;
`else
    logic [CNT_W-1:0] unused_stall;
    assign unused_stall = '0;
`endif

endmodule

// File: tb/tb_dff_skid_slice.sv
// Directed bench for dff_skid_slice: driver pushes accepted words into a queue, a monitor pops and compares delivered words.
// Stall counter scenarios are compiled in when DFF_SKID_STALL_CNT_EN is defined.
module tb_dff_skid_slice;

    logic       clk;
    logic       rst;
    logic [4:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [4:0] out_data;
    logic       out_valid;
    logic       out_ready;

    int checks = 0;
    int errors = 0;
    int cnt = 0;
    logic [4:0] exp_q[$];

`ifdef DFF_SKID_STALL_CNT_EN
    logic [15:0] stall_cnt;
    logic [2:0]  stall_cnt_s;
    logic        in_ready_s;
    logic [4:0]  out_data_s;
    logic        out_valid_s;
`endif

    dff_skid_slice #(.N(5), .CNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef DFF_SKID_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

`ifdef DFF_SKID_STALL_CNT_EN
    dff_skid_slice #(.N(5), .CNT_W(3)) dut_small (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready_s),
        .out_data  (out_data_s),
        .out_valid (out_valid_s),
        .out_ready (out_ready),
        .stall_cnt (stall_cnt_s)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Present a word and wait (bounded) until the slice takes it.
    task automatic send(input logic [4:0] w);
        in_data  = w;
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                exp_q.push_back(w);
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                in_data  = 5'bx;
                return;
            end
            @(posedge clk);
            #1;
        end
        checks++;
        errors++;
        $display("FAIL send_timeout word=%0h not accepted at %0t", w, $time);
        in_valid = 1'b0;
    endtask

    // Occupancy model plus ordered data scoreboard; fires are decided here just before the posedge.
    always @(negedge clk) begin
        logic in_f;
        logic out_f;
        logic [4:0] w;
        if (rst) begin
            cnt = 0;
            exp_q.delete();
        end else begin
            chk("out_valid_vs_occupancy", {31'd0, out_valid}, {31'd0, cnt != 0});
            chk("in_ready_vs_occupancy", {31'd0, in_ready}, {31'd0, cnt != 2});
            out_f = (cnt != 0) && out_ready;
            in_f  = in_valid && (cnt != 2);
            if (out_f) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL scoreboard_underflow actual=%0h expected=none", out_data);
                end else begin
                    w = exp_q.pop_front();
                    chk("out_data_order", {27'd0, out_data}, {27'd0, w});
                end
            end
            cnt = cnt + (in_f ? 1 : 0) - (out_f ? 1 : 0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_data   = 5'b11111;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset_out_data", {27'd0, out_data}, 32'd0);
        rst      = 1'b0;
        in_valid = 1'b0;

        // Streaming, one word per cycle
        out_ready = 1'b1;
        send(5'b10101);
        chk("latency_valid", {31'd0, out_valid}, 32'd1);
        chk("latency_data", {27'd0, out_data}, 32'b10101);
        send(5'b01010);
        chk("stream_data2", {27'd0, out_data}, 32'b01010);
        send(5'b11100);
        chk("stream_data3", {27'd0, out_data}, 32'b11100);
        @(posedge clk);
        #1;
        chk("stream_drained", {31'd0, out_valid}, 32'd0);

        // Backpressure fill to TWO
        out_ready = 1'b0;
        send(5'b10101);
        send(5'b01010);
        chk("fill_in_ready", {31'd0, in_ready}, 32'd0);
        chk("fill_out_valid", {31'd0, out_valid}, 32'd1);
        chk("fill_out_data", {27'd0, out_data}, 32'b10101);
        in_data  = 5'b11111;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("third_word_blocked", {31'd0, in_ready}, 32'd0);
            chk("stable_under_stall", {27'd0, out_data}, 32'b10101);
        end
        in_valid = 1'b0;

        // Drain
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("drain_second", {27'd0, out_data}, 32'b01010);
        chk("drain_second_valid", {31'd0, out_valid}, 32'd1);
        @(posedge clk);
        #1;
        chk("drain_empty_valid", {31'd0, out_valid}, 32'd0);
        chk("drain_empty_ready", {31'd0, in_ready}, 32'd1);

        // Reset while holding two words
        out_ready = 1'b0;
        send(5'b00111);
        send(5'b11000);
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 5'b11111;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("midrst_out_data", {27'd0, out_data}, 32'd0);
        out_ready = 1'b1;
        send(5'b00011);
        chk("post_rst_word", {27'd0, out_data}, 32'b00011);
        repeat (2) @(posedge clk);
        #1;

`ifdef DFF_SKID_STALL_CNT_EN
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("stall_reset", {16'd0, stall_cnt}, 32'd0);
        out_ready = 1'b0;
        send(5'b10001);
        repeat (7) @(posedge clk);
        #1;
        chk("stall_cnt_7", {16'd0, stall_cnt}, 32'd7);
        chk("stall_small_7", {29'd0, stall_cnt_s}, 32'd7);
        repeat (3) @(posedge clk);
        #1;
        chk("stall_cnt_10", {16'd0, stall_cnt}, 32'd10);
        chk("stall_small_sat", {29'd0, stall_cnt_s}, 32'd7);
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("stall_hold_after", {16'd0, stall_cnt}, 32'd10);
`endif

        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
